// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment bus: digit count,
// active-low segment codes (dp off) and decode helpers.
package seg_pkg;

   localparam int unsigned SEG_N = 6;

   // Active-low codes, bit 7 = dp (1 = off), bits 6:0 = g..a
   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;
   localparam logic [7:0] SEG_A = 8'h88;
   localparam logic [7:0] SEG_B = 8'h83;
   localparam logic [7:0] SEG_C = 8'hC6;
   localparam logic [7:0] SEG_D = 8'hA1;
   localparam logic [7:0] SEG_E = 8'h86;
   localparam logic [7:0] SEG_F = 8'h8E;

   localparam logic [7:0] SEG_CODE [16] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
      SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
   };

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_HELD
   } scan_state_e;

   // Returns {hit, nibble}; hit=0 when the pattern is not a hex glyph
   function automatic logic [4:0] seg_to_hex(input logic [6:0] s);
      logic [4:0] r;
      r = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (!r[4] && (SEG_CODE[i][6:0] == s)) begin
            r = {1'b1, 4'(i)};
         end
      end
      return r;
   endfunction

   // Returns {ok, idx}; ok=1 only when exactly one select bit is low
   function automatic logic [3:0] onehot_low_idx(input logic [SEG_N-1:0] sel);
      logic [SEG_N-1:0] act;
      logic [3:0]       r;
      act = ~sel;
      r   = '0;
      if ((act != '0) && ((act & (act - 1'b1)) == '0)) begin
         r[3] = 1'b1;
         for (int unsigned i = 0; i < SEG_N; i++) begin
            if (act[i]) begin
               r[2:0] = 3'(i);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus bundle between the scanned display lines and the decoder readback.
// master drives sel/seg (display side), slave is the decoder.
interface seg_scan_decoder_if
   import seg_pkg::*;
   ();

   logic [SEG_N-1:0]   sel;
   logic [7:0]         seg;
   logic [4*SEG_N-1:0] digits;
   logic [SEG_N-1:0]   dp;
   logic [SEG_N-1:0]   digit_valid;
   logic               frame_done;
   logic               seg_err;
   logic               sel_err;
   logic               stale;

   modport master (
      output sel, seg,
      input  digits, dp, digit_valid, frame_done, seg_err, sel_err, stale
   );

   modport slave (
      input  sel, seg,
      output digits, dp, digit_valid, frame_done, seg_err, sel_err, stale
   );

endinterface

// File: rtl/seg_sync_stable.sv
// Synchronises sel/seg, detects any change against the previous sample and
// strobes once when both have been unchanged for SETTLE_CYC cycles.
module seg_sync_stable
   import seg_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned SETTLE_CYC  = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [SEG_N-1:0] sel_i,
   input  logic [7:0]       seg_i,
   output logic [SEG_N-1:0] sel_o,
   output logic [7:0]       seg_o,
   output logic             change_o,
   output logic             settled_o
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   logic [SEG_N-1:0] sel_sync_q [SYNC_STAGES];
   logic [7:0]       seg_sync_q [SYNC_STAGES];
   logic [SEG_N-1:0] prev_sel_q;
   logic [7:0]       prev_seg_q;
   logic [CNT_W-1:0] cnt_q;
   logic             armed_q;
   logic             settled_q;
   logic [SEG_N-1:0] s_sel;
   logic [7:0]       s_seg;
   logic             change;

   assign s_sel  = sel_sync_q[SYNC_STAGES-1];
   assign s_seg  = seg_sync_q[SYNC_STAGES-1];
   assign change = (s_sel != prev_sel_q) || (s_seg != prev_seg_q);

   // Synchroniser chain and compare register; reset to the idle (blank) bus
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sel_sync_q[i] <= '1;
            seg_sync_q[i] <= '1;
         end
         prev_sel_q <= '1;
         prev_seg_q <= '1;
      end else begin
         sel_sync_q[0] <= sel_i;
         seg_sync_q[0] <= seg_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sel_sync_q[i] <= sel_sync_q[i-1];
            seg_sync_q[i] <= seg_sync_q[i-1];
         end
         prev_sel_q <= s_sel;
         prev_seg_q <= s_seg;
      end
   end

   // Stable counter: re-armed by every change, fires a single strobe per settle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         settled_q <= 1'b0;
      end else begin
         settled_q <= 1'b0;
         if (change) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
         end else if (armed_q) begin
            if (cnt_q == CNT_LAST) begin
               armed_q   <= 1'b0;
               settled_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   // The compare register holds exactly the values that were stable while counting
   assign sel_o     = prev_sel_q;
   assign seg_o     = prev_seg_q;
   assign change_o  = change;
   assign settled_o = settled_q;

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the six-digit multiplexed seven-segment bus: captures each
// settled digit slot, decodes it to hex + dp and tracks frames and staleness.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 5000
) (
   input  logic              clk,
   input  logic              rstn,
   seg_scan_decoder_if.slave bus
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   scan_state_e        state_q;
   logic [4*SEG_N-1:0] digits_q, digits_d;
   logic [SEG_N-1:0]   dp_q, dp_d;
   logic [SEG_N-1:0]   valid_q, valid_d;
   logic [SEG_N-1:0]   mask_q, mask_d;
   logic               frame_done_q;
   logic               seg_err_q;
   logic               sel_err_q;
   logic               stale_q;
   logic [TMO_W-1:0]   tmo_q;

   logic [SEG_N-1:0]   set_sel;
   logic [7:0]         set_seg;
   logic               change;
   logic               settled;
   logic               settle_done;
   logic [3:0]         sel_chk;
   logic [4:0]         seg_chk;
   logic [2:0]         slot_k;
   logic               sel_ok;
   logic               sel_blank;
   logic               cap_hit;

   seg_sync_stable #(
      .SYNC_STAGES (SYNC_STAGES),
      .SETTLE_CYC  (SETTLE_CYC)
   ) u_sync (
      .clk       (clk),
      .rstn      (rstn),
      .sel_i     (bus.sel),
      .seg_i     (bus.seg),
      .sel_o     (set_sel),
      .seg_o     (set_seg),
      .change_o  (change),
      .settled_o (settled)
   );

   // Decode the settled slot and form the post-capture storage values
   always_comb begin
      settle_done = settled && (state_q == ST_SETTLE);
      sel_chk     = onehot_low_idx(set_sel);
      seg_chk     = seg_to_hex(set_seg[6:0]);
      slot_k      = sel_chk[2:0];
      sel_ok      = sel_chk[3];
      sel_blank   = &set_sel;
      cap_hit     = settle_done && sel_ok && seg_chk[4];

      digits_d                   = digits_q;
      digits_d[{slot_k, 2'b00} +: 4] = seg_chk[3:0];
      dp_d                       = dp_q;
      dp_d[slot_k]               = ~set_seg[7];
      valid_d                    = valid_q;
      valid_d[slot_k]            = 1'b1;
      mask_d                     = mask_q | (SEG_N'(1) << slot_k);
   end

   // Scan FSM with capture, frame tracking and timeout; all outputs registered
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_WAIT;
         digits_q     <= '0;
         dp_q         <= '0;
         valid_q      <= '0;
         mask_q       <= '0;
         frame_done_q <= 1'b0;
         seg_err_q    <= 1'b0;
         sel_err_q    <= 1'b0;
         stale_q      <= 1'b0;
         tmo_q        <= '0;
      end else begin
         frame_done_q <= 1'b0;
         seg_err_q    <= 1'b0;
         sel_err_q    <= 1'b0;

         // A change arriving together with the settle strobe re-enters SETTLE,
         // keeping the FSM aligned with the re-armed stable counter
         case (state_q)
            ST_WAIT, ST_HELD: begin
               if (change) state_q <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_done && !change) state_q <= sel_blank ? ST_WAIT : ST_HELD;
            end
            default: state_q <= ST_WAIT;
         endcase

         if (cap_hit) begin
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            stale_q  <= 1'b0;
            tmo_q    <= '0;
            if (slot_k == 3'd0) begin
               frame_done_q <= (mask_d == '1);
               mask_q       <= '0;
            end else begin
               mask_q <= mask_d;
            end
         end else begin
            if (settle_done && sel_ok) seg_err_q <= 1'b1;
            if (settle_done && !sel_ok && !sel_blank) sel_err_q <= 1'b1;
            if (tmo_q == TMO_LAST) begin
               stale_q <= 1'b1;
               valid_q <= '0;
               mask_q  <= '0;
            end else begin
               tmo_q <= tmo_q + 1'b1;
            end
         end
      end
   end

   assign bus.digits      = digits_q;
   assign bus.dp          = dp_q;
   assign bus.digit_valid = valid_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.seg_err     = seg_err_q;
   assign bus.sel_err     = sel_err_q;
   assign bus.stale       = stale_q;

endmodule
